// File: rtl/rreg_pkg.sv
// Shared types and helpers for the read-register mux arbiter.
// RREG_PARITY_EN widens the Pi transfer to 9 bits (byte + odd parity).
package rreg_pkg;

  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_B = 2'd1;
  localparam logic [1:0] REG_C = 2'd2;
  localparam logic [1:0] REG_D = 2'd3;

`ifdef RREG_PARITY_EN
  localparam int SH_LEN = 9;
`else
  localparam int SH_LEN = 8;
`endif

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEL  = 2'd1,
    ARB_CAP  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_WAIT  = 2'd1,
    SH_SHIFT = 2'd2
  } sh_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_TI   = 2'd1,
    OWN_PI   = 2'd2
  } owner_e;

  function automatic logic [3:0] onehot4(
    input logic [1:0] idx
  );
    logic [3:0] oh;
    oh = 4'b0000;
    unique case (idx)
      REG_A: oh = 4'b0001;
      REG_B: oh = 4'b0010;
      REG_C: oh = 4'b0100;
      REG_D: oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input
// followed by a single-cycle rising-edge pulse.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rreg_read_arbiter.sv
// Shares the read-register mux between the TI bus and the Pi serial port.
// Define RREG_PARITY_EN for a 9-bit Pi transfer with odd parity.
module rreg_read_arbiter
  import rreg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ti_rd_req,
  input  logic [1:0] ti_rd_sel,
  output logic [7:0] ti_rd_data,
  output logic       ti_rd_valid,
  input  logic       pi_ld,
  input  logic [1:0] pi_sel,
  input  logic       pi_sclk,
  output logic       pi_sdata,
  output logic       pi_busy,
  output logic [3:0] mux_sel,
  input  logic [7:0] mux_o
);

  logic ld_rise;
  logic sclk_rise;
  logic [SYNC_STAGES-1:0][1:0] sel_sync_q;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ld (
    .clk    (clk),
    .reset  (reset),
    .d_i    (pi_ld),
    .rise_o (ld_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk    (clk),
    .reset  (reset),
    .d_i    (pi_sclk),
    .rise_o (sclk_rise)
  );

  logic ti_req_q;
  logic ti_edge;
  logic ti_pend_q, ti_pend_d;
  logic pi_pend_q, pi_pend_d;
  logic [1:0] ti_idx_q, ti_idx_d;
  logic [1:0] pi_idx_q, pi_idx_d;

  arb_state_e arb_q, arb_d;
  owner_e     own_q, own_d;
  logic       grant_ti, grant_pi, cap_pi;
  logic [3:0] mux_sel_q, mux_sel_d;
  logic [7:0] ti_data_q, ti_data_d;
  logic       ti_valid_q, ti_valid_d;

  sh_state_e         sh_q, sh_d;
  logic [SH_LEN-1:0] shreg_q, shreg_d;
  logic [SH_LEN-1:0] sh_load;
  logic [3:0]        cnt_q, cnt_d;

  assign ti_edge = ti_rd_req & ~ti_req_q;

`ifdef RREG_PARITY_EN
  assign sh_load = {mux_o, ~^mux_o};
`else
  assign sh_load = mux_o;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_sync_q <= '0;
      ti_req_q   <= 1'b0;
      ti_pend_q  <= 1'b0;
      pi_pend_q  <= 1'b0;
      ti_idx_q   <= 2'd0;
      pi_idx_q   <= 2'd0;
      arb_q      <= ARB_IDLE;
      own_q      <= OWN_NONE;
      mux_sel_q  <= 4'd0;
      ti_data_q  <= 8'd0;
      ti_valid_q <= 1'b0;
      sh_q       <= SH_IDLE;
      shreg_q    <= '0;
      cnt_q      <= 4'd0;
    end else begin
      sel_sync_q <= {sel_sync_q[SYNC_STAGES-2:0], pi_sel};
      ti_req_q   <= ti_rd_req;
      ti_pend_q  <= ti_pend_d;
      pi_pend_q  <= pi_pend_d;
      ti_idx_q   <= ti_idx_d;
      pi_idx_q   <= pi_idx_d;
      arb_q      <= arb_d;
      own_q      <= own_d;
      mux_sel_q  <= mux_sel_d;
      ti_data_q  <= ti_data_d;
      ti_valid_q <= ti_valid_d;
      sh_q       <= sh_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
    end
  end

  // A fresh edge wins over the clear from a same-cycle grant.
  always_comb begin
    ti_pend_d = ti_pend_q;
    ti_idx_d  = ti_idx_q;
    pi_pend_d = pi_pend_q;
    pi_idx_d  = pi_idx_q;
    if (grant_ti) ti_pend_d = 1'b0;
    if (grant_pi) pi_pend_d = 1'b0;
    if (ti_edge) begin
      ti_pend_d = 1'b1;
      ti_idx_d  = ti_rd_sel;
    end
    if (ld_rise) begin
      pi_pend_d = 1'b1;
      pi_idx_d  = sel_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    arb_d    = arb_q;
    own_d    = own_q;
    grant_ti = 1'b0;
    grant_pi = 1'b0;
    unique case (arb_q)
      ARB_IDLE: begin
        if (ti_pend_q) begin
          grant_ti = 1'b1;
          own_d    = OWN_TI;
          arb_d    = ARB_SEL;
        end else if (pi_pend_q) begin
          grant_pi = 1'b1;
          own_d    = OWN_PI;
          arb_d    = ARB_SEL;
        end
      end
      ARB_SEL: arb_d = ARB_CAP;
      ARB_CAP: begin
        arb_d = ARB_IDLE;
        own_d = OWN_NONE;
      end
      default: begin
        arb_d = ARB_IDLE;
        own_d = OWN_NONE;
      end
    endcase
  end

  always_comb begin
    mux_sel_d  = mux_sel_q;
    ti_data_d  = ti_data_q;
    ti_valid_d = 1'b0;
    cap_pi     = 1'b0;
    if (grant_ti) mux_sel_d = onehot4(ti_idx_q);
    if (grant_pi) mux_sel_d = onehot4(pi_idx_q);
    if (arb_q == ARB_CAP) begin
      mux_sel_d = 4'd0;
      if (own_q == OWN_TI) begin
        ti_data_d  = mux_o;
        ti_valid_d = 1'b1;
      end
      if (own_q == OWN_PI) cap_pi = 1'b1;
    end
  end

  // A new load during a shift restarts from the recaptured byte.
  always_comb begin
    sh_d    = sh_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (sh_q)
      SH_IDLE: if (ld_rise) sh_d = SH_WAIT;
      SH_WAIT: begin
        if (cap_pi && !ld_rise) begin
          sh_d    = SH_SHIFT;
          shreg_d = sh_load;
          cnt_d   = 4'd0;
        end
      end
      SH_SHIFT: begin
        if (ld_rise) begin
          sh_d = SH_WAIT;
        end else if (sclk_rise) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'(SH_LEN - 1)) sh_d = SH_IDLE;
        end
      end
      default: sh_d = SH_IDLE;
    endcase
  end

  assign ti_rd_data  = ti_data_q;
  assign ti_rd_valid = ti_valid_q;
  assign mux_sel     = mux_sel_q;
  assign pi_busy     = (sh_q != SH_IDLE);
  assign pi_sdata    = (sh_q == SH_SHIFT) & shreg_q[SH_LEN-1];

endmodule

// File: tb/tb_rreg_read_arbiter.sv
// Directed bench for rreg_read_arbiter with a four-register mux model.
// Honours RREG_PARITY_EN for the Pi transfer length.
module tb_rreg_read_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ti_rd_req = 1'b0;
  logic [1:0] ti_rd_sel = 2'd0;
  logic [7:0] ti_rd_data;
  logic       ti_rd_valid;
  logic       pi_ld = 1'b0;
  logic [1:0] pi_sel = 2'd0;
  logic       pi_sclk = 1'b0;
  logic       pi_sdata;
  logic       pi_busy;
  logic [3:0] mux_sel;
  logic [7:0] mux_o;

  logic [7:0] regs [4];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    mux_o = 8'd0;
    for (int i = 0; i < 4; i++)
      if (mux_sel[i]) mux_o = mux_o | regs[i];
  end

  rreg_read_arbiter #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .ti_rd_req   (ti_rd_req),
    .ti_rd_sel   (ti_rd_sel),
    .ti_rd_data  (ti_rd_data),
    .ti_rd_valid (ti_rd_valid),
    .pi_ld       (pi_ld),
    .pi_sel      (pi_sel),
    .pi_sclk     (pi_sclk),
    .pi_sdata    (pi_sdata),
    .pi_busy     (pi_busy),
    .mux_sel     (mux_sel),
    .mux_o       (mux_o)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_mux(string tag, logic [3:0] exp);
    for (int i = 0; i < 30; i++) begin
      if (mux_sel != 4'd0) break;
      step();
    end
    chk(tag, {28'd0, mux_sel}, {28'd0, exp});
  endtask

  task automatic pi_load(string tag, logic [3:0] exp);
    pi_ld = 1'b1;
    wait_mux(tag, exp);
    step();
    step();
    pi_ld = 1'b0;
    repeat (3) step();
  endtask

  task automatic sclk_pulse();
    pi_sclk = 1'b1;
    repeat (4) step();
    pi_sclk = 1'b0;
    repeat (4) step();
  endtask

  task automatic shift_bits(string tag, logic [7:0] b,
                            int nb);
    logic [8:0] v;
    int n;
`ifdef RREG_PARITY_EN
    v = {b, ~^b};
    n = 9;
`else
    v = {1'b0, b};
    n = 8;
`endif
    if (nb < n) n = nb;
    for (int i = 0; i < n; i++) begin
`ifdef RREG_PARITY_EN
      chk(tag, {31'd0, pi_sdata}, {31'd0, v[8-i]});
`else
      chk(tag, {31'd0, pi_sdata}, {31'd0, v[7-i]});
`endif
      sclk_pulse();
    end
  endtask

  initial begin
    regs[0] = 8'h00;
    regs[1] = 8'h00;
    regs[2] = 8'h5A;
    regs[3] = 8'h11;
    repeat (2) step();
    chk("rst_mux", {28'd0, mux_sel}, 32'd0);
    chk("rst_valid", {31'd0, ti_rd_valid}, 32'd0);
    chk("rst_data", {24'd0, ti_rd_data}, 32'd0);
    chk("rst_busy", {31'd0, pi_busy}, 32'd0);
    chk("rst_sdata", {31'd0, pi_sdata}, 32'd0);
    reset = 1'b0;
    step();

    // TI read of register c
    ti_rd_sel = 2'd2;
    ti_rd_req = 1'b1;
    step();
    chk("ti_n", {28'd0, mux_sel}, 32'd0);
    step();
    chk("ti_n1_mux", {28'd0, mux_sel}, 32'h4);
    step();
    chk("ti_n2_mux", {28'd0, mux_sel}, 32'h4);
    chk("ti_n2_valid", {31'd0, ti_rd_valid}, 32'd0);
    step();
    chk("ti_n3_valid", {31'd0, ti_rd_valid}, 32'd1);
    chk("ti_n3_data", {24'd0, ti_rd_data}, 32'h5A);
    chk("ti_n3_mux", {28'd0, mux_sel}, 32'd0);
    step();
    chk("ti_n4_valid", {31'd0, ti_rd_valid}, 32'd0);
    chk("ti_hold", {24'd0, ti_rd_data}, 32'h5A);
    ti_rd_req = 1'b0;
    step();

    // Pi read of register b
    regs[1] = 8'hC3;
    pi_sel = 2'd1;
    repeat (4) step();
    pi_load("pi_b_mux", 4'b0010);
    chk("pi_b_busy", {31'd0, pi_busy}, 32'd1);
    shift_bits("pi_b_bit", 8'hC3, 9);
    chk("pi_b_done", {31'd0, pi_busy}, 32'd0);
    chk("pi_b_sd0", {31'd0, pi_sdata}, 32'd0);

    // simultaneous TI and Pi edges
    regs[0] = 8'h96;
    pi_sel = 2'd0;
    ti_rd_sel = 2'd3;
    repeat (4) step();
    pi_ld = 1'b1;
    step();
    step();
    ti_rd_req = 1'b1;
    step();
    step();
    chk("tie_ti_mux", {28'd0, mux_sel}, 32'h8);
    step();
    step();
    chk("tie_ti_valid", {31'd0, ti_rd_valid}, 32'd1);
    chk("tie_ti_data", {24'd0, ti_rd_data}, 32'h11);
    chk("tie_cap_mux", {28'd0, mux_sel}, 32'd0);
    step();
    chk("tie_pi_mux", {28'd0, mux_sel}, 32'h1);
    step();
    step();
    pi_ld = 1'b0;
    ti_rd_req = 1'b0;
    repeat (3) step();
    shift_bits("tie_pi_bit", 8'h96, 9);
    chk("tie_pi_done", {31'd0, pi_busy}, 32'd0);

    // abort after 3 shift clocks
    regs[1] = 8'hF0;
    pi_sel = 2'd1;
    repeat (4) step();
    pi_load("ab_mux0", 4'b0010);
    shift_bits("ab_part", 8'hF0, 3);
    regs[1] = 8'h0F;
    pi_load("ab_mux1", 4'b0010);
    chk("ab_busy", {31'd0, pi_busy}, 32'd1);
    shift_bits("ab_bit", 8'h0F, 9);
    chk("ab_done", {31'd0, pi_busy}, 32'd0);

    // reset in the middle of a shift
    regs[3] = 8'h3C;
    pi_sel = 2'd3;
    repeat (4) step();
    pi_load("rs_mux", 4'b1000);
    shift_bits("rs_part", 8'h3C, 4);
    chk("rs_pre_sd", {31'd0, pi_sdata}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rs_busy", {31'd0, pi_busy}, 32'd0);
    chk("rs_sdata", {31'd0, pi_sdata}, 32'd0);
    chk("rs_data", {24'd0, ti_rd_data}, 32'd0);
    chk("rs_mux0", {28'd0, mux_sel}, 32'd0);
    step();
    reset = 1'b0;
    regs[2] = 8'hA5;
    pi_sel = 2'd2;
    repeat (4) step();
    pi_load("rs2_mux", 4'b0100);
    shift_bits("rs2_bit", 8'hA5, 9);
    chk("rs2_done", {31'd0, pi_busy}, 32'd0);

    // byte 0x07 (parity bit 0 when enabled)
    regs[1] = 8'h07;
    pi_sel = 2'd1;
    repeat (4) step();
    pi_load("p7_mux", 4'b0010);
    shift_bits("p7_bit", 8'h07, 9);
    chk("p7_done", {31'd0, pi_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
